// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide unit with architectural HI/LO registers.
// Computes one bit per cycle: shift-add multiply and restoring divide on
// unsigned magnitudes, followed by a one-cycle sign fix-up that writes HI/LO.
// Also accepts MTHI/MTLO writes while idle; HI/LO are always visible.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [1:0]  i_op_2,
    input  logic [31:0] w_data_s1val_32,
    input  logic [31:0] w_data_s2val_32,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    output logic [31:0] w_data_hi_32,
    output logic [31:0] w_data_lo_32,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [4:0]  count_reg;
    logic        is_div_reg;
    logic        neg_res_reg;    // result (product / quotient) must be negated
    logic        neg_rem_reg;    // remainder takes the dividend's sign
    logic        div_zero_reg;
    logic [31:0] rs_reg;         // raw dividend, returned in HI on divide by zero
    logic [31:0] opnd_reg;       // multiplicand magnitude or divisor magnitude
    logic [31:0] acc_reg;        // product high half or partial remainder
    logic [31:0] work_reg;       // multiplier bits / product low half, or dividend bits / quotient
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        done_reg;

    // Operand conditioning at start: magnitudes and result sign flags
    logic        op_signed;
    logic        s1_neg;
    logic        s2_neg;
    logic [31:0] s1_mag;
    logic [31:0] s2_mag;

    assign op_signed = ~i_op_2[0];
    assign s1_neg    = op_signed & w_data_s1val_32[31];
    assign s2_neg    = op_signed & w_data_s2val_32[31];
    assign s1_mag    = s1_neg ? (~w_data_s1val_32 + 32'd1) : w_data_s1val_32;
    assign s2_mag    = s2_neg ? (~w_data_s2val_32 + 32'd1) : w_data_s2val_32;

    // One iteration of shift-add multiply (carry-out becomes the new top bit)
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_reg} + (work_reg[0] ? {1'b0, opnd_reg} : 33'd0);

    // One iteration of restoring divide: shift in next dividend bit, trial subtract.
    // When the subtraction succeeds the difference is below the divisor, so the
    // low 32 bits of the modular difference are exact.
    logic [32:0] div_shift;
    logic        div_ok;
    logic [31:0] div_diff;
    assign div_shift = {acc_reg, work_reg[31]};
    assign div_ok    = (div_shift >= {1'b0, opnd_reg});
    assign div_diff  = div_shift[31:0] - opnd_reg;

    // Sign fix-up applied in FINISH
    logic [63:0] product_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    assign product_fix = neg_res_reg ? (~{acc_reg, work_reg} + 64'd1) : {acc_reg, work_reg};
    assign quot_fix    = neg_res_reg ? (~work_reg + 32'd1) : work_reg;
    assign rem_fix     = neg_rem_reg ? (~acc_reg + 32'd1) : acc_reg;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> CALC (32 iterations) -> FINISH -> IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = CALC;
            CALC:    if (count_reg == 5'd31) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, per-cycle iteration, result write-back and moves
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= 5'd0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            rs_reg       <= 32'd0;
            opnd_reg     <= 32'd0;
            acc_reg      <= 32'd0;
            work_reg     <= 32'd0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        is_div_reg   <= i_op_2[1];
                        neg_res_reg  <= s1_neg ^ s2_neg;
                        neg_rem_reg  <= s1_neg;
                        div_zero_reg <= (w_data_s2val_32 == 32'd0);
                        rs_reg       <= w_data_s1val_32;
                        count_reg    <= 5'd0;
                        acc_reg      <= 32'd0;
                        if (i_op_2[1]) begin
                            opnd_reg <= s2_mag;
                            work_reg <= s1_mag;
                        end else begin
                            opnd_reg <= s1_mag;
                            work_reg <= s2_mag;
                        end
                    end else begin
                        if (i_mthi) hi_reg <= w_data_s1val_32;
                        if (i_mtlo) lo_reg <= w_data_s1val_32;
                    end
                end
                CALC: begin
                    count_reg <= count_reg + 5'd1;
                    if (is_div_reg) begin
                        acc_reg  <= div_ok ? div_diff : div_shift[31:0];
                        work_reg <= {work_reg[30:0], div_ok};
                    end else begin
                        acc_reg  <= mul_sum[32:1];
                        work_reg <= {mul_sum[0], work_reg[31:1]};
                    end
                end
                FINISH: begin
                    done_reg <= 1'b1;
                    if (is_div_reg) begin
                        if (div_zero_reg) begin
                            hi_reg <= rs_reg;
                            lo_reg <= 32'hFFFF_FFFF;
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end
                    end else begin
                        hi_reg <= product_fix[63:32];
                        lo_reg <= product_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_data_hi_32 = hi_reg;
    assign w_data_lo_32 = lo_reg;
    assign o_busy       = (state_reg != IDLE);
    assign o_done       = done_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed test-plan vectors plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_mult_div_unit;

    logic        clock;
    logic        reset_n;
    logic        i_start;
    logic [1:0]  i_op_2;
    logic [31:0] w_data_s1val_32;
    logic [31:0] w_data_s2val_32;
    logic        i_mthi;
    logic        i_mtlo;
    logic [31:0] w_data_hi_32;
    logic [31:0] w_data_lo_32;
    logic        o_busy;
    logic        o_done;

    int errors = 0;
    int checks = 0;

    mult_div_unit dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .i_start         (i_start),
        .i_op_2          (i_op_2),
        .w_data_s1val_32 (w_data_s1val_32),
        .w_data_s2val_32 (w_data_s2val_32),
        .i_mthi          (i_mthi),
        .i_mtlo          (i_mtlo),
        .w_data_hi_32    (w_data_hi_32),
        .w_data_lo_32    (w_data_lo_32),
        .o_busy          (o_busy),
        .o_done          (o_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Architectural result {HI, LO} of an operation, from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = 64'd0;
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Behavioural model: 33-cycle latency, moves only while idle, async reset
    logic [31:0] m_hi, m_lo;
    logic        m_busy, m_done;
    logic [63:0] m_res;
    int          m_left;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end else if (i_start) begin
                m_res  <= ref_result(i_op_2, w_data_s1val_32, w_data_s2val_32);
                m_busy <= 1'b1;
                m_left <= 33;
            end else begin
                if (i_mthi) m_hi <= w_data_s1val_32;
                if (i_mtlo) m_lo <= w_data_s1val_32;
            end
        end
    end

    // Per-cycle compare of every output against the model
    int cycle = 0;
    always @(negedge clock) begin
        cycle++;
        checks++;
        if (w_data_hi_32 !== m_hi || w_data_lo_32 !== m_lo ||
            o_busy !== m_busy || o_done !== m_done) begin
            errors++;
            $display("FAIL cycle %0d model: got hi=%h lo=%h busy=%b done=%b, want hi=%h lo=%h busy=%b done=%b",
                     cycle, w_data_hi_32, w_data_lo_32, o_busy, o_done,
                     m_hi, m_lo, m_busy, m_done);
        end
    end

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // Present a start for one cycle; returns at the negedge after the sampling edge
    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        i_op_2          = op;
        w_data_s1val_32 = a;
        w_data_s2val_32 = b;
        i_start         = 1'b1;
        @(negedge clock);
        i_start         = 1'b0;
    endtask

    // Wait (bounded) for o_done; lat0 = negedges already seen since the start edge
    task automatic wait_done(input string name, input int lat0,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        lat = lat0;
        while (!o_done && lat < 45) begin
            @(negedge clock);
            lat++;
        end
        check_val({name, " latency"}, 64'(lat), 64'd34);
        check_val({name, " result"}, {w_data_hi_32, w_data_lo_32}, {exp_hi, exp_lo});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Test-plan vectors that pin the reference model itself
    logic [1:0]  pin_op [8] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    logic [31:0] pin_a  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9,
                                32'd100, 32'h1234_5678, 32'h8000_0000, 32'd9};
    logic [31:0] pin_b  [8] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2,
                                32'd7, 32'd0, 32'hFFFF_FFFF, 32'd3};
    logic [63:0] pin_r  [8] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                                64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFD,
                                64'h0000_0002_0000_000E, 64'h1234_5678_FFFF_FFFF,
                                64'h0000_0000_8000_0000, 64'h0000_0000_0000_0003};

    initial begin
        i_start = 0; i_op_2 = 0; w_data_s1val_32 = 0; w_data_s2val_32 = 0;
        i_mthi = 0; i_mtlo = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        check_val("reset state", {w_data_hi_32, w_data_lo_32, 30'd0, o_busy, o_done}, 96'd0);

        for (int i = 0; i < 8; i++)
            check_val($sformatf("model pin %0d", i), ref_result(pin_op[i], pin_a[i], pin_b[i]), pin_r[i]);

        // Directed test-plan operations on the DUT (first seven vectors)
        for (int i = 0; i < 7; i++) begin
            start_op(pin_op[i], pin_a[i], pin_b[i]);
            wait_done($sformatf("op %0d", i), 1, pin_r[i][63:32], pin_r[i][31:0]);
        end

        // Re-start at E5 and MTHI at E10 are ignored while busy
        start_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        repeat (4) @(negedge clock);
        i_op_2 = 2'b11; w_data_s1val_32 = 32'd100; w_data_s2val_32 = 32'd7; i_start = 1'b1;
        @(negedge clock);
        i_start = 1'b0;
        repeat (4) @(negedge clock);
        w_data_s1val_32 = 32'hDEAD_BEEF; i_mthi = 1'b1;
        @(negedge clock);
        i_mthi = 1'b0;
        wait_done("busy ignore", 11, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // MTLO in idle: LO takes rs, HI unchanged
        @(negedge clock);
        w_data_s1val_32 = 32'hCAFE_BABE; i_mtlo = 1'b1;
        @(negedge clock);
        i_mtlo = 1'b0;
        check_val("mtlo", {w_data_hi_32, w_data_lo_32}, {32'hFFFF_FFFF, 32'hCAFE_BABE});

        // Asynchronous reset in the middle of a MULTU
        @(negedge clock);
        i_op_2 = 2'b01; w_data_s1val_32 = 32'hFFFF_FFFF; w_data_s2val_32 = 32'hFFFF_FFFF; i_start = 1'b1;
        @(posedge clock);
        #1 i_start = 1'b0;
        repeat (12) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_val("async reset", {w_data_hi_32, w_data_lo_32, 31'd0, o_busy}, 96'd0);
        @(negedge clock);
        reset_n = 1'b1;
        start_op(2'b11, 32'd9, 32'd3);
        wait_done("divu after reset", 1, 32'd0, 32'd3);

        // Randomized traffic: starts and moves at any time, checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            i_start         = ($urandom_range(3) == 0);
            i_op_2          = 2'($urandom_range(3));
            w_data_s1val_32 = pick();
            w_data_s2val_32 = pick();
            i_mthi          = ($urandom_range(4) == 0);
            i_mtlo          = ($urandom_range(4) == 0);
        end
        @(negedge clock);
        i_start = 0; i_mthi = 0; i_mtlo = 0;
        repeat (40) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
